// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: FSM state encoding, default LFSR geometry
// (shared with the PRBS generator) and the next-bit helper.
package prbs_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int PRBS_WIDTH = 5;
    localparam int PRBS_TAP1  = 4;
    localparam int PRBS_TAP2  = 2;

    // Feedback bit of a left-shifting Fibonacci LFSR (new bit enters at [0]).
    function automatic logic prbs_next_bit(input logic [31:0] sr, input int tap1, input int tap2);
        return sr[tap1] ^ sr[tap2];
    endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Block error monitor: counts errors over fixed, non-sliding blocks of WIN
// valid bits and flags loss when a block's tally reaches ERR_LIMIT.
// loss_o is combinational so the FSM can leave LOCKED on the same edge.
module prbs_err_window #(
    parameter int WIN       = 32,
    parameter int ERR_LIMIT = 8
) (
    input  logic clk,
    input  logic RST,
    input  logic valid_i,
    input  logic err_i,
    input  logic clear_i,
    output logic loss_o
);

    localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int EW = $clog2(ERR_LIMIT + 1);

    logic [CW-1:0] pos_q;
    logic [EW-1:0] blk_err_q;

    // Loss fires on the error that brings the tally up to the limit.
    always_comb begin
        loss_o = valid_i && err_i && (blk_err_q == EW'(ERR_LIMIT - 1));
    end

    // Block position and error tally; both restart at each block boundary.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pos_q     <= '0;
            blk_err_q <= '0;
        end else if (clear_i || loss_o) begin
            pos_q     <= '0;
            blk_err_q <= '0;
        end else if (valid_i) begin
            if (pos_q == CW'(WIN - 1)) begin
                pos_q     <= '0;
                blk_err_q <= '0;
            end else begin
                pos_q     <= pos_q + CW'(1);
                blk_err_q <= blk_err_q + EW'(err_i);
            end
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: seeds a local LFSR from received bits, hunts for
// LOCK_CNT consecutive correct predictions, then free-runs and counts errors.
// Optional macro PRBS_CHK_BITCNT_EN adds a 32-bit count of bits seen while locked.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int WIDTH     = PRBS_WIDTH,
    parameter int TAP1      = PRBS_TAP1,
    parameter int TAP2      = PRBS_TAP2,
    parameter int LOCK_CNT  = 8,
    parameter int WIN       = 32,
    parameter int ERR_LIMIT = 8,
    parameter int ERR_W     = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state_o
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam int SCW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [SCW-1:0]   seed_cnt_q, seed_cnt_d;
    logic [7:0]       match_q, match_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             pred, mis, lk_valid, loss;

    assign pred     = prbs_next_bit(32'(sr_q), TAP1, TAP2);
    assign mis      = bit_in ^ pred;
    assign lk_valid = bit_valid && (state_q == LOCKED);

    prbs_err_window #(.WIN(WIN), .ERR_LIMIT(ERR_LIMIT)) u_win (
        .clk     (clk),
        .RST     (RST),
        .valid_i (lk_valid),
        .err_i   (mis),
        .clear_i (state_q != LOCKED),
        .loss_o  (loss)
    );

    // Next-state logic: seed, hunt for lock, free-run once locked.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        seed_cnt_d = seed_cnt_q;
        match_d    = match_q;
        case (state_q)
            SEED: if (bit_valid) begin
                sr_d    = {sr_q[WIDTH-2:0], bit_in};
                match_d = '0;
                if (seed_cnt_q == SCW'(WIDTH - 1)) begin
                    seed_cnt_d = '0;
                    // An all-zero seed would lock the LFSR up; collect again.
                    if (sr_d != '0) state_d = HUNT;
                end else begin
                    seed_cnt_d = seed_cnt_q + SCW'(1);
                end
            end
            HUNT: if (bit_valid) begin
                // Always load received data, so a mismatch re-seeds for free.
                sr_d = {sr_q[WIDTH-2:0], bit_in};
                if (mis) begin
                    match_d = '0;
                end else if (match_q == 8'(LOCK_CNT - 1)) begin
                    match_d = '0;
                    state_d = LOCKED;
                end else begin
                    match_d = match_q + 8'(1);
                end
            end
            LOCKED: if (bit_valid) begin
                // Free-run on the prediction so a bad bit is counted once only.
                sr_d = {sr_q[WIDTH-2:0], pred};
                if (loss) begin
                    state_d    = SEED;
                    seed_cnt_d = '0;
                    match_d    = '0;
                end
            end
            default: begin
                state_d    = SEED;
                seed_cnt_d = '0;
                match_d    = '0;
            end
        endcase
    end

    // Error pulse and saturating counter; a same-cycle clear wins.
    always_comb begin
        err_pulse_d = lk_valid && mis;
        err_count_d = err_count_q;
        if (err_pulse_d && (err_count_q != '1)) err_count_d = err_count_q + ERR_W'(1);
        if (clr_cnt) err_count_d = '0;
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= SEED;
            sr_q        <= '0;
            seed_cnt_q  <= '0;
            match_q     <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            seed_cnt_q  <= seed_cnt_d;
            match_q     <= match_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state_o   = state_q;

`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_count_q;

    // Bits received while locked; survives loss of lock, wraps at 2^32.
    always_ff @(posedge clk or posedge RST) begin
        if (RST)           bit_count_q <= '0;
        else if (clr_cnt)  bit_count_q <= '0;
        else if (lk_valid) bit_count_q <= bit_count_q + 32'd1;
    end

    assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised scoreboard bench for prbs_checker: a default instance and an
// ERR_W=4 instance share stimulus; a sequence-level model predicts outputs.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        bit_in = 1'b0, bit_valid = 1'b0, clr_cnt = 1'b0;
    logic        locked, err_pulse, s_locked, s_err_pulse;
    logic [15:0] err_count;
    logic [3:0]  s_err_count;
    logic [1:0]  state_o, s_state_o;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_count, s_bit_count;
`endif

    always #5 clk = ~clk;

    prbs_checker u_dut (
        .clk(clk), .RST(RST), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state_o(state_o)
`ifdef PRBS_CHK_BITCNT_EN
        , .bit_count(bit_count)
`endif
    );

    prbs_checker #(.ERR_W(4)) u_sat (
        .clk(clk), .RST(RST), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count), .state_o(s_state_o)
`ifdef PRBS_CHK_BITCNT_EN
        , .bit_count(s_bit_count)
`endif
    );

    typedef struct {
        int lk; int st; int ep; int ec; int ec4; int unsigned bc;
    } exp_t;

    exp_t q[$];
    int   n_total = 0, n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model (sequence level) ----------------
    // hist holds the last 5 bits of the local sequence, oldest first;
    // a period-31 m-sequence obeys s[n] = s[n-5] ^ s[n-3].
    bit          hist[$];
    int          m_mode, m_seed, m_match, m_pos, m_berr, m_ec, m_ec4;
    int unsigned m_bc;
    bit [4:0]    g;   // stimulus generator register

    function automatic bit gen_bit();
        bit b;
        b = g[4] ^ g[2];
        g = {g[3:0], b};
        return b;
    endfunction

    task automatic model_reset();
        hist = '{0, 0, 0, 0, 0};
        m_mode = 0; m_seed = 0; m_match = 0; m_pos = 0; m_berr = 0;
        m_ec = 0; m_ec4 = 0; m_bc = 0;
    endtask

    task automatic model_step(input bit b, input bit v, input bit clr);
        bit   p, nz;
        exp_t e;
        int   pulse;
        pulse = 0;
        p = hist[0] ^ hist[2];
        if (v) begin
            if (m_mode == 2) m_bc++;
            case (m_mode)
                0: begin
                    hist.push_back(b); void'(hist.pop_front());
                    m_seed++;
                    if (m_seed == 5) begin
                        m_seed = 0;
                        nz = 0;
                        foreach (hist[i]) nz |= hist[i];
                        if (nz) begin m_mode = 1; m_match = 0; end
                    end
                end
                1: begin
                    hist.push_back(b); void'(hist.pop_front());
                    if (b == p) begin
                        m_match++;
                        if (m_match == 8) begin m_mode = 2; m_match = 0; m_pos = 0; m_berr = 0; end
                    end else m_match = 0;
                end
                default: begin
                    hist.push_back(p); void'(hist.pop_front());
                    m_pos++;
                    if (b != p) begin
                        pulse = 1;
                        if (m_ec < 65535) m_ec++;
                        if (m_ec4 < 15) m_ec4++;
                        m_berr++;
                    end
                    if (m_berr == 8) begin m_mode = 0; m_seed = 0; m_pos = 0; m_berr = 0; end
                    else if (m_pos == 32) begin m_pos = 0; m_berr = 0; end
                end
            endcase
        end
        if (clr) begin m_ec = 0; m_ec4 = 0; m_bc = 0; end
        e.lk = (m_mode == 2); e.st = m_mode; e.ep = pulse;
        e.ec = m_ec; e.ec4 = m_ec4; e.bc = m_bc;
        q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit b, input bit v, input bit clr);
        @(negedge clk);
        bit_in = b; bit_valid = v; clr_cnt = clr;
        model_step(b, v, clr);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) drive(gen_bit(), 1'b1, 1'b0);
    endtask

    // Step past the next edge; the monitor has consumed the entry by now.
    task automatic settle();
        @(posedge clk); #2;
    endtask

    // Asynchronous reset, checked before any clock edge can intervene.
    task automatic do_reset();
        bit_valid = 1'b0; clr_cnt = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_locked", locked, 0);    chk("rst_state", state_o, 0);
        chk("rst_pulse", err_pulse, 0);  chk("rst_count", err_count, 0);
        chk("rst_s_locked", s_locked, 0); chk("rst_s_count", s_err_count, 0);
        model_reset();
        g = 5'b00001;
        @(negedge clk);
        RST = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("locked", locked, e.lk);
                chk("state_o", state_o, e.st);
                chk("err_pulse", err_pulse, e.ep);
                chk("err_count", err_count, e.ec);
                chk("sat_err_count", s_err_count, e.ec4);
                chk("sat_locked", s_locked, e.lk);
`ifdef PRBS_CHK_BITCNT_EN
                chk("bit_count", int'(bit_count), int'(e.bc));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        bit b;
        int burst;
        #2;
        do_reset();

        // Clean stream: lock after valid bit 13 (5 seed + 8 matches).
        for (int i = 1; i <= 1000; i++) begin
            drive(gen_bit(), 1'b1, 1'b0);
            if (i == 12) begin settle(); chk("lock_after_12", locked, 0); end
            if (i == 13) begin settle(); chk("lock_after_13", locked, 1); end
        end
        settle();
        chk("clean_count", err_count, 0);

        // Single inverted bit while locked.
        for (int i = 1; i <= 100; i++) begin
            b = gen_bit();
            drive((i == 40) ? ~b : b, 1'b1, 1'b0);
        end
        settle();
        chk("single_err_count", err_count, 1);
        chk("single_err_locked", locked, 1);

        // All-zero burst forces loss of lock, then relock on clean data.
        for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, 1'b0);
        settle();
        chk("zeros_locked", locked, 0);
        chk("zeros_state", state_o, 0);
        clean(100);
        settle();
        chk("relock", locked, 1);

        // All-zero seed is discarded.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0);
        settle();
        chk("zero_seed_state", state_o, 0);
        clean(30);
        settle();
        chk("zero_seed_lock", locked, 1);

        // Three errors, then clear coinciding with a fourth.
        for (int k = 0; k < 3; k++) begin
            clean(9);
            drive(~gen_bit(), 1'b1, 1'b0);
        end
        settle();
        chk("three_errs", err_count, 3);
        drive(~gen_bit(), 1'b1, 1'b1);
        settle();
        chk("clr_wins_count", err_count, 0);
        chk("clr_wins_pulse", err_pulse, 1);

        // 20 spaced errors: 16-bit counter reads 20, 4-bit saturates at 15.
        for (int k = 0; k < 20; k++) begin
            clean(4);
            drive(~gen_bit(), 1'b1, 1'b0);
        end
        settle();
        chk("sat_15", s_err_count, 15);
        chk("count_20", err_count, 20);
        chk("sat_locked_kept", locked, 1);

        // One valid bit in three.
        do_reset();
        for (int c = 0; c < 60; c++) begin
            if (c % 3 == 0) drive(gen_bit(), 1'b1, 1'b0);
            else            drive(1'($urandom), 1'b0, 1'b0);
        end
        settle();
        chk("gapped_lock", locked, 1);

        // Random valid pattern, errors, zero bursts and clears.
        burst = 0;
        for (int c = 0; c < 2000; c++) begin
            bit v, clr;
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 99) == 0);
            if (v) begin
                b = gen_bit();
                if ($urandom_range(0, 39) == 0) b = ~b;
                if (burst == 0 && $urandom_range(0, 299) == 0) burst = 40;
                if (burst > 0) begin b = 1'b0; burst--; end
            end else b = 1'($urandom);
            drive(b, v, clr);
        end

        // Reset asserted mid-cycle while locked.
        clean(60);
        settle();
        chk("pre_rst_locked", locked, 1);
        do_reset();

        settle();
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
